div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 29 ++
 rtl/div_step.sv | 30 +++
 rtl/div_ctrl.sv | 160 ++++++++++++++++
 tb/tb_div_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared defines for the divide unit: execute-stage op codes, the divider
// state encoding, the default operand width and the HI/LO field offsets
// inside the packed {remainder, quotient} result.
package div_ctrl_pkg;

  // Execute-stage operation codes (MIPS funct encoding)
  localparam logic [5:0] EXE_MULT_OP  = 6'h18;
  localparam logic [5:0] EXE_MULTU_OP = 6'h19;
  localparam logic [5:0] EXE_DIV_OP   = 6'h1a;
  localparam logic [5:0] EXE_DIVU_OP  = 6'h1b;

  // Default operand width and iteration counter width (2^CNT_W > DIV_W)
  localparam int DIV_W_DEF = 32;
  localparam int CNT_W_DEF = 6;

  // Quotient (LO) sits at bit 0; remainder (HI) sits one operand width up
  localparam int LO_OFS = 0;

  function automatic int hi_ofs(input int w);
    return w;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the partial remainder left,
// pulling in the next dividend bit from the top of the quotient register,
// trial-subtract the divisor and shift the resulting quotient bit in.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // Since rem_in < divisor, diff[W] is a clean borrow flag for the trial subtract
  always_comb begin
    shifted = {rem_in, quo_in[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[W]) begin
      rem_out = diff[W-1:0];
      quo_out = {quo_in[W-2:0], 1'b1};
    end else begin
      rem_out = shifted[W-1:0];
      quo_out = {quo_in[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Iterative restoring divider control for DIV/DIVU. One quotient bit per
// cycle on operand magnitudes, sign fix-up applied when the result is
// written into hilo_div = {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and
// goes straight from IDLE to DONE (same result value either way).
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [DIV_W-1:0]   opa,
  input  logic [DIV_W-1:0]   opb,
  input  logic               annul,
  output logic               stall,
  output logic               busy,
  output logic               ready,
  output logic [2*DIV_W-1:0] hilo_div
);

  localparam int               HI_OFS    = hi_ofs(DIV_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);
  localparam logic [DIV_W-1:0] ONES      = '1;

  div_state_e         state;
  logic [CNT_W-1:0]   count;
  logic [DIV_W-1:0]   rem_q;
  logic [DIV_W-1:0]   quo_q;
  logic [DIV_W-1:0]   dvs_q;
  logic               quo_neg_q;
  logic               rem_neg_q;
  logic               zero_q;

  logic               sign_a;
  logic               sign_b;
  logic [DIV_W-1:0]   mag_a;
  logic [DIV_W-1:0]   mag_b;
  logic [DIV_W-1:0]   rem_nxt;
  logic [DIV_W-1:0]   quo_nxt;
  logic [DIV_W-1:0]   quo_fix;
  logic [DIV_W-1:0]   rem_fix;
  logic [2*DIV_W-1:0] result;
`ifdef DIV_ZERO_FAST_EN
  logic [2*DIV_W-1:0] zero_result;
`endif

  // Operand signs and magnitudes at issue; DIVU treats both as non-negative
  always_comb begin
    sign_a = signed_div & opa[DIV_W-1];
    sign_b = signed_div & opb[DIV_W-1];
    mag_a  = sign_a ? -opa : opa;
    mag_b  = sign_b ? -opb : opb;
  end

  div_step #(.W(DIV_W)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // Final result from the last step. With a zero divisor every trial subtract
  // succeeds and the dividend magnitude shifts into the remainder untouched,
  // so re-applying the dividend sign recovers the original opa for HI.
  always_comb begin
    quo_fix = quo_neg_q ? -quo_nxt : quo_nxt;
    rem_fix = rem_neg_q ? -rem_nxt : rem_nxt;
    result  = '0;
    result[HI_OFS +: DIV_W] = rem_fix;
    result[LO_OFS +: DIV_W] = zero_q ? ONES : quo_fix;
  end

`ifdef DIV_ZERO_FAST_EN
  // Divide-by-zero result taken straight from the issuing operands
  always_comb begin
    zero_result = '0;
    zero_result[HI_OFS +: DIV_W] = opa;
    zero_result[LO_OFS +: DIV_W] = ONES;
  end
`endif

  // Pipeline hold: the issuing cycle plus every iteration cycle
  always_comb begin
    stall = resetn & (((state == IDLE) & start & ~annul) | (state == CALC));
  end

  // Main FSM with registered busy/ready and the result register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      zero_q    <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      hilo_div  <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            rem_q     <= '0;
            quo_q     <= mag_a;
            dvs_q     <= mag_b;
            quo_neg_q <= sign_a ^ sign_b;
            rem_neg_q <= sign_a;
            zero_q    <= (opb == '0);
            count     <= '0;
`ifdef DIV_ZERO_FAST_EN
            if (opb == '0) begin
              state    <= DONE;
              ready    <= 1'b1;
              hilo_div <= zero_result;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
`else
            state <= CALC;
            busy  <= 1'b1;
`endif
          end
        end
        CALC: begin
          if (annul) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            count <= count + CNT_W'(1);
            if (count == LAST_STEP) begin
              state    <= DONE;
              busy     <= 1'b0;
              ready    <= 1'b1;
              hilo_div <= result;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl (DIV_W = 32). Issued divides push their
// expected {remainder, quotient} and ready cycle; a negedge monitor pops and
// compares whenever ready is seen. Honours DIV_ZERO_FAST_EN for latency.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        stall;
  logic        busy;
  logic        ready;
  logic [63:0] hilo_div;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] last_hilo = '0;

  typedef struct {
    logic [63:0] hilo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  div_ctrl #(.DIV_W(32), .CNT_W(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .annul      (annul),
    .stall      (stall),
    .busy       (busy),
    .ready      (ready),
    .hilo_div   (hilo_div)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain 64-bit integer division, truncating toward zero
  function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sbv, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sbv = longint'({32'd0, b});
    end
    q = sa / sbv;
    r = sa % sbv;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one start pulse; called just after a rising edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn, input bit track);
    exp_t e;
    opa = a;
    opb = b;
    signed_div = sgn;
    start = 1'b1;
    if (track) begin
      e.hilo = refDiv(a, b, sgn);
      e.cyc  = cyc + ((b == 32'd0) ? ZERO_LAT : 33);
      sb.push_back(e);
      last_hilo = e.hilo;
    end
    @(negedge clk);
    checkOutput("stall_at_start", {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    opa = $urandom;
    opb = $urandom;
    signed_div = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) until every expected result has been seen
  task automatic waitDone();
    int i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (sb.size() != 0 && i < 100);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL ready_timeout: got no ready after %0d cycles, expected %0d pending results", i, sb.size());
      sb.delete();
    end
    #1;
  endtask

  // Monitor: pop and compare whenever the DUT presents a result
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn && ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_ready: got ready=1 hilo=0x%0h at cycle %0d, expected no result", hilo_div, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("hilo_div", hilo_div, e.hilo);
        checkOutput("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] a, b;
    logic        sgn;

    // Reset state, with start held high to show stall is gated by reset
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_stall", {63'd0, stall}, 64'd0);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_ready", {63'd0, ready}, 64'd0);
    checkOutput("reset_hilo", hilo_div, 64'd0);
    start = 1'b0;

    // DIVU 100/7 issued on the first edge after release; full stall/busy/ready trace
    resetn = 1'b1;
    applyStimulus(32'd100, 32'd7, 1'b0, 1'b1);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      checkOutput("stall_trace", {63'd0, stall}, {63'd0, (k <= 32)});
      checkOutput("busy_trace", {63'd0, busy}, {63'd0, (k <= 32)});
      checkOutput("ready_trace", {63'd0, ready}, {63'd0, (k == 33)});
    end
    waitDone();
    checkOutput("divu_100_7", hilo_div, 64'h0000_0002_0000_000E);

    // Signed corner cases and divide by zero
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    waitDone();
    checkOutput("div_m7_2", hilo_div, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    waitDone();
    checkOutput("div_min_m1", hilo_div, 64'h0000_0000_8000_0000);
    applyStimulus(32'd5, 32'd0, 1'b0, 1'b1);
    waitDone();
    checkOutput("divu_5_0", hilo_div, 64'h0000_0005_FFFF_FFFF);
    applyStimulus(32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1);
    waitDone();

    // Result held in IDLE
    repeat (3) @(negedge clk);
    checkOutput("hilo_hold", hilo_div, last_hilo);
    @(posedge clk);
    #1;

    // Annul at start+10, then a fresh 9/3
    applyStimulus(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    @(negedge clk);
    checkOutput("annul_stall", {63'd0, stall}, 64'd0);
    checkOutput("annul_busy", {63'd0, busy}, 64'd0);
    checkOutput("annul_hilo_kept", hilo_div, last_hilo);
    @(posedge clk);
    #1;
    applyStimulus(32'd9, 32'd3, 1'b0, 1'b1);
    waitDone();
    checkOutput("divu_9_3", hilo_div, 64'h0000_0000_0000_0003);

    // start together with annul in IDLE must not launch a divide
    opa = 32'd50;
    opb = 32'd5;
    start = 1'b1;
    annul = 1'b1;
    @(negedge clk);
    checkOutput("start_annul_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    checkOutput("start_annul_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1;

    // Reset at start+5, then a normal divide right after release
    applyStimulus(32'd1234567, 32'd89, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("busy_before_reset", {63'd0, busy}, 64'd1);
    resetn = 1'b0;
    #1;
    checkOutput("midop_reset_stall", {63'd0, stall}, 64'd0);
    checkOutput("midop_reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("midop_reset_ready", {63'd0, ready}, 64'd0);
    checkOutput("midop_reset_hilo", hilo_div, 64'd0);
    last_hilo = '0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    applyStimulus(32'd1234567, 32'd89, 1'b0, 1'b1);
    waitDone();

    // Randomised divides, sometimes with a stray start during CALC
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 6))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = $urandom; b = -($urandom_range(1, 255)); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      sgn = 1'($urandom_range(0, 1));
      applyStimulus(a, b, sgn, 1'b1);
      if (b != 32'd0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 20)) begin
          @(posedge clk);
          #1;
        end
        start = 1'b1;
        opa = $urandom;
        opb = $urandom;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      waitDone();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
